// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: merges load-use, HI/LO, mul/div structural and memory-wait
// hazards plus taken-branch flushes. Optional stall-cycle counter under PIPE_CTRL_PERF_EN.
module pipeline_ctrl #(
   parameter int unsigned MUL_LAT = 4,
   parameter int unsigned DIV_LAT = 32,
   parameter int unsigned CNT_W   = 6
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        MemReadE,
   input  logic [4:0]  RtAddrE,
   input  logic [4:0]  RsAddrD,
   input  logic [4:0]  RtAddrD,
   input  logic        UsesRsD,
   input  logic        UsesRtD,
   input  logic        HiLoReadD,
   input  logic        MulDivStartE,
   input  logic        MulDivOpE,
   input  logic        BranchTakenE,
   input  logic        MemWaitM,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE,
   output logic        StallM,
   output logic        FlushD,
   output logic        FlushE,
   output logic        FlushW,
   output logic        MulDivBusy,
   output logic [15:0] StallCycles
);

   typedef enum logic {StIdle, StMdBusy} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               start_accept;
   logic               lu_hazard, hl_hazard, sh_hazard;

   assign MulDivBusy   = (state_q == StMdBusy);
   // A start waiting behind a busy unit is accepted only once the FSM is back in idle.
   assign start_accept = MulDivStartE & ~MemWaitM & ~MulDivBusy;

   assign lu_hazard = MemReadE & (RtAddrE != 5'd0) &
                      ((UsesRsD & (RsAddrD == RtAddrE)) | (UsesRtD & (RtAddrD == RtAddrE)));
   assign hl_hazard = HiLoReadD & (MulDivBusy | MulDivStartE);
   assign sh_hazard = MulDivStartE & MulDivBusy;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (start_accept) begin
               state_d = StMdBusy;
               cnt_d   = MulDivOpE ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
            end
         end
         StMdBusy: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = StIdle;
            end
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (Reset) begin
         // all controls stay low
      end else if (MemWaitM) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else if (sh_hazard) begin
         // E holds a mul/div, so a branch in E cannot be taken this cycle.
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
      end else if (BranchTakenE) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else if (lu_hazard | hl_hazard) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (StallF && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign StallCycles = stall_cnt_q;
`else
   assign StallCycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard scenarios followed by random traffic,
// all compared against a cycle-level reference model of the hazard rules.
module tb_pipeline_ctrl;

   localparam int MulLat = 4;
   localparam int DivLat = 32;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        MemReadE;
   logic [4:0]  RtAddrE, RsAddrD, RtAddrD;
   logic        UsesRsD, UsesRtD, HiLoReadD;
   logic        MulDivStartE, MulDivOpE, BranchTakenE, MemWaitM;
   logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MulDivBusy;
   logic [15:0] StallCycles;

   int checks = 0;
   int errors = 0;
   int md_left = 0;
   int perf_exp = 0;

   always #5 Clock = ~Clock;

   pipeline_ctrl #(
      .MUL_LAT(MulLat),
      .DIV_LAT(DivLat),
      .CNT_W  (6)
   ) u_dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .MemReadE    (MemReadE),
      .RtAddrE     (RtAddrE),
      .RsAddrD     (RsAddrD),
      .RtAddrD     (RtAddrD),
      .UsesRsD     (UsesRsD),
      .UsesRtD     (UsesRtD),
      .HiLoReadD   (HiLoReadD),
      .MulDivStartE(MulDivStartE),
      .MulDivOpE   (MulDivOpE),
      .BranchTakenE(BranchTakenE),
      .MemWaitM    (MemWaitM),
      .StallF      (StallF),
      .StallD      (StallD),
      .StallE      (StallE),
      .StallM      (StallM),
      .FlushD      (FlushD),
      .FlushE      (FlushE),
      .FlushW      (FlushW),
      .MulDivBusy  (MulDivBusy),
      .StallCycles (StallCycles)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW} from the priority rules.
   function automatic logic [6:0] exp_ctl();
      bit busy = (md_left > 0);
      bit lu = MemReadE && (RtAddrE != 0) &&
               ((UsesRsD && RsAddrD == RtAddrE) || (UsesRtD && RtAddrD == RtAddrE));
      bit hl = HiLoReadD && (busy || MulDivStartE);
      bit sh = MulDivStartE && busy;
      if (Reset)        return 7'b0000000;
      if (MemWaitM)     return 7'b1111001;
      if (sh)           return 7'b1110000;
      if (BranchTakenE) return 7'b0000110;
      if (lu || hl)     return 7'b1100010;
      return 7'b0000000;
   endfunction

   // Check one cycle at the falling edge, then advance the model across the rising edge.
   task automatic step();
      logic [6:0] e;
      @(negedge Clock);
      e = exp_ctl();
      check_eq("ctl", {25'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, {25'd0, e});
      check_eq("busy", {31'd0, MulDivBusy}, (md_left > 0) ? 32'd1 : 32'd0);
      check_eq("perf", {16'd0, StallCycles}, perf_exp);
      @(posedge Clock);
      if (Reset) begin
         md_left  = 0;
         perf_exp = 0;
      end else begin
         if (md_left > 0) md_left--;
         else if (MulDivStartE && !MemWaitM) md_left = MulDivOpE ? DivLat : MulLat;
`ifdef PIPE_CTRL_PERF_EN
         if (e[6] && perf_exp < 65535) perf_exp++;
`endif
      end
      #1;
   endtask

   task automatic idle_inputs();
      Reset = 0; MemReadE = 0; RtAddrE = 0; RsAddrD = 0; RtAddrD = 0;
      UsesRsD = 0; UsesRtD = 0; HiLoReadD = 0; MulDivStartE = 0; MulDivOpE = 0;
      BranchTakenE = 0; MemWaitM = 0;
   endtask

   initial begin
      int busy_cycles;
      idle_inputs();
      Reset = 1;
      step();
      step();
      Reset = 0;
      step();

      // Load-use on Rs, then the same with r0 as destination.
      MemReadE = 1; RtAddrE = 5; RsAddrD = 5; UsesRsD = 1;
      step();
      idle_inputs();
      step();
      MemReadE = 1; RtAddrE = 0; RsAddrD = 0; UsesRsD = 1;
      step();
      idle_inputs();

      // Multiply followed by MFHI; busy must last exactly MulLat cycles.
      MulDivStartE = 1; MulDivOpE = 0;
      step();
      MulDivStartE = 0; HiLoReadD = 1;
      busy_cycles = 0;
      for (int i = 0; i < 8; i++) begin
         if (MulDivBusy) busy_cycles++;
         step();
      end
      check_eq("mul_busy_len", busy_cycles, MulLat);
      idle_inputs();

      // Divide, then a second op arrives 3 cycles later and waits for the unit.
      MulDivStartE = 1; MulDivOpE = 1;
      step();
      MulDivStartE = 0;
      step();
      step();
      MulDivStartE = 1; MulDivOpE = 0;
      for (int i = 0; i < 40 && md_left > 0; i++) step();
      step();
      check_eq("second_accepted", md_left, MulLat);
      MulDivStartE = 0;
      for (int i = 0; i < 6; i++) step();

      // Memory wait over load-use and branch, then release.
      MemWaitM = 1; MemReadE = 1; RtAddrE = 7; RtAddrD = 7; UsesRtD = 1; BranchTakenE = 1;
      for (int i = 0; i < 3; i++) step();
      MemWaitM = 0;
      step();
      idle_inputs();
      step();

      // Reset in the middle of a divide.
      MulDivStartE = 1; MulDivOpE = 1;
      step();
      MulDivStartE = 0;
      for (int i = 0; i < 12; i++) step();
      check_eq("div_left", md_left, 20);
      Reset = 1; HiLoReadD = 1;
      step();
      Reset = 0;
      step();
      idle_inputs();

      for (int i = 0; i < 4000; i++) begin
         Reset        = ($urandom % 300) == 0;
         MemReadE     = $urandom % 2;
         RtAddrE      = 5'($urandom % 4);
         RsAddrD      = 5'($urandom % 4);
         RtAddrD      = 5'($urandom % 4);
         UsesRsD      = $urandom % 2;
         UsesRtD      = $urandom % 2;
         HiLoReadD    = ($urandom % 3) == 0;
         MulDivStartE = ($urandom % 6) == 0;
         MulDivOpE    = ($urandom % 3) == 0;
         BranchTakenE = ($urandom % 5) == 0;
         MemWaitM     = ($urandom % 6) == 0;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
